// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// The clog2 helper sizes the write pointer and program-length fields.
package imem_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LOAD = 2'd1,
        S_BUSY = 2'd2
    } imem_state_e;

    localparam logic [31:0] NOOP_INSTR = 32'h0;

    // Result bookkeeping for the fetch in flight.
    typedef struct packed {
        logic pend;
        logic inb;
    } fetch_tag_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port RAM with synchronous write and synchronous read.
// A write takes the port; reads are only issued when no write is pending.
module imem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int AW         = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: streaming program load, then fetches with
// configurable wait states; anything beyond the loaded program reads as NOOP.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0,
    localparam int PLW        = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_err,
    output logic [PLW-1:0]        prog_len,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr
);

    localparam int         AW_R = clog2(DEPTH);
    localparam logic [3:0] WS   = 4'(WAIT_STATES);

    imem_state_e           state, state_n;
    logic [PLW-1:0]        wr_ptr;
    logic [3:0]            wcnt;
    fetch_tag_t            tag;
    logic                  accept, beat, load_end, enter_load;
    logic                  busy_done, rd_due, in_range;
    logic [AW_R-1:0]       ram_addr;
    logic [DATA_WIDTH-1:0] ram_q;

    assign in_range = fetch_addr < ADDR_WIDTH'(prog_len);
    assign ram_addr = (state == S_LOAD) ? wr_ptr[AW_R-1:0] : fetch_addr[AW_R-1:0];

    imem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW_R)
    ) u_ram (
        .clk   (clk),
        .we    (beat),
        .re    (accept),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (ram_q)
    );

    always_comb begin
        state_n     = state;
        fetch_ready = 1'b0;
        load_ready  = 1'b0;
        accept      = 1'b0;
        beat        = 1'b0;
        load_end    = 1'b0;
        enter_load  = 1'b0;
        busy_done   = 1'b0;
        case (state)
            S_RUN: begin
                fetch_ready = !load_start;
                if (load_start) begin
                    enter_load = 1'b1;
                    state_n    = S_LOAD;
                end else if (fetch_req) begin
                    accept = 1'b1;
                    if (WAIT_STATES != 0) begin
                        state_n = S_BUSY;
                    end
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    beat = 1'b1;
                    if (load_last || wr_ptr == PLW'(DEPTH - 1)) begin
                        load_end = 1'b1;
                        state_n  = S_RUN;
                    end
                end
            end
            S_BUSY: begin
                // Leave one cycle early so the result pulse lands after
                // exactly WAIT_STATES idle cycles.
                if (wcnt <= 4'd1) begin
                    busy_done = 1'b1;
                    state_n   = S_RUN;
                end
            end
            default: state_n = S_RUN;
        endcase
    end

    assign rd_due = (accept && WAIT_STATES == 0) || busy_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            prog_len    <= '0;
            wr_ptr      <= '0;
            wcnt        <= '0;
            tag         <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            state       <= state_n;
            instr_valid <= 1'b0;
            tag.pend    <= rd_due;
            // A result still in flight when a load starts is dropped so it
            // never overlaps load_ready.
            if (tag.pend && !enter_load) begin
                instr_valid <= 1'b1;
                instr       <= tag.inb ? ram_q : DATA_WIDTH'(NOOP_INSTR);
            end
            if (accept) begin
                tag.inb <= in_range;
                wcnt    <= WS;
            end else if (state == S_BUSY && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
            if (enter_load) begin
                wr_ptr   <= '0;
                load_err <= 1'b0;
            end
            if (beat) begin
                wr_ptr <= wr_ptr + PLW'(1);
                if (load_end) begin
                    prog_len <= wr_ptr + PLW'(1);
                    if (!load_last) begin
                        load_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, loadable instruction memory for the mini CPU. It replaces hard-wired program ROMs with a synchronous RAM that is filled at run time through a streaming load port, then serves instruction fetches through a request/valid handshake with configurable wait states. Any word outside the loaded program reads as NOOP (all zeros). It sits between the CPU fetch stage and the testbench or boot loader.

## Interface
- DATA_WIDTH, 32: instruction width.
- ADDR_WIDTH, 32: fetch address (PC) width. The PC is a word index.
- DEPTH, 64: number of instruction words; must be ≥2.
- WAIT_STATES, 0: extra cycles between fetch acceptance and `instr_valid`; 0–15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse to begin loading a program.
- load_valid  in  1  a load beat is present.
- load_data  in  DATA_WIDTH  instruction word to write.
- load_last  in  1  marks the final beat of the program.
- load_ready  out  1  high in LOAD state.
- load_err  out  1  sticky; the program was truncated at DEPTH without `load_last`.
- prog_len  out  clog2(DEPTH+1)  number of valid words currently loaded.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  PC of the requested word.
- fetch_ready  out  1  a request is accepted when `fetch_req` and `fetch_ready` are both high.
- instr_valid  out  1  one-cycle pulse; `instr` carries the fetched word.
- instr  out  DATA_WIDTH  fetched instruction; holds its value between pulses.

## Operation
- States: RUN, LOAD, BUSY. The state encoding lives in the package.
- Reset clears the following:
  - state → RUN, `prog_len` → 0, `wr_ptr` → 0, wait counter → 0.
  - `instr` → 0, `instr_valid` → 0, `load_err` → 0.
  - RAM contents are not cleared. Because `prog_len` is 0, every fetch returns NOOP.
- RUN:
  - `fetch_ready` = !`load_start`.
  - If `load_start` is high, go to LOAD, set `wr_ptr` = 0 and `load_err` = 0. A `fetch_req` in the same cycle is not accepted; load wins.
  - Otherwise, an accepted fetch latches the address.
    - With WAIT_STATES=0, state stays RUN and the result appears next cycle. Back-to-back fetches give one result per cycle.
    - With WAIT_STATES>0, go to BUSY with counter = WAIT_STATES.
- BUSY:
  - `fetch_ready`=0.
  - The counter decrements each cycle. When it reaches 0, `instr_valid` pulses the next cycle and state returns to RUN.
- LOAD:
  - `load_ready`=1 and `fetch_ready`=0. `load_start` is ignored.
  - On each beat with `load_valid` high: `mem[wr_ptr]` ← `load_data`, then `wr_ptr`++.
  - If the beat has `load_last` high, or `wr_ptr`==DEPTH-1: `prog_len` ← `wr_ptr`+1 and go to RUN.
  - If the end came from hitting DEPTH-1 without `load_last`, set `load_err`.
- Fetch result:
  - `instr` = `mem[fetch_addr]` if `fetch_addr` < `prog_len`; otherwise 0 (NOOP).
  - The comparison uses the full ADDR_WIDTH, so any nonzero upper bits give NOOP.
- `prog_len` changes only at load completion. The old program remains fetchable until then in the sense that it is overwritten in place; a reset mid-load leaves `prog_len`=0.

## Timing
- Fetch latency from the acceptance edge to the `instr_valid` edge is 1+WAIT_STATES cycles.
- Throughput is 1/(1+WAIT_STATES) fetches per cycle.
- Load writes one word per cycle while `load_valid` is held.
- `prog_len` updates on the same edge as the last write. A fetch accepted on the following cycle sees the new program.
- Reset asserted during BUSY drops the pending fetch; no `instr_valid` is issued.
- `instr_valid` is never high in the same cycle as `load_ready`.

## Structure
- Package `imem_pkg` holds:
  - the state enum (`S_RUN`, `S_LOAD`, `S_BUSY`);
  - `NOOP_INSTR` = 32'h0;
  - a `clog2` helper, if the tool flow lacks one.
- Sub-module `imem_ram`: single-port RAM, DEPTH×DATA_WIDTH, synchronous write and synchronous read. A single port suffices because load and fetch are mutually exclusive.
- The top level contains the FSM, `wr_ptr`, the wait counter, the bounds check and the output register.

## Test plan
- Reset, then fetch addr 0 → `instr_valid` one cycle later, `instr`=0, `prog_len`=0.
- Load 23 words, words 0 and 22 = 32'hE400FFFF and 32'h0, `load_last` on beat 23 → `prog_len`=23. Fetch 0 → 32'hE400FFFF. Fetch 23 → 0.
- WAIT_STATES=3, fetch addr 6 → `instr_valid` exactly 4 cycles after acceptance; `fetch_ready` low for 3 cycles.
- DEPTH=8, stream 10 beats without `load_last` → 8 beats accepted, `load_ready` low after beat 8, `load_err`=1, `prog_len`=8.
- `load_start` and `fetch_req` in the same cycle → no fetch accepted; LOAD entered; `load_ready`=1 next cycle.
- Reset after 5 of 10 load beats → state RUN, `prog_len`=0, fetch addr 2 returns 0.
